// File: rtl/fproc_meas_hub.sv
// Measurement result hub: N_MEAS result slots answered to N_CORES fproc request channels, round-robin.
// Optional FPROC_STALE_BLOCK_EN holds requests for a slot until it has been updated since its last read.
module fproc_meas_hub #(
  parameter int N_CORES        = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int N_MEAS         = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      meas_valid   [N_MEAS],
  input  logic [DATA_WIDTH-1:0]     meas_data    [N_MEAS],
  input  logic                      fproc_enable [N_CORES],
  input  logic [FPROC_ID_WIDTH-1:0] fproc_id     [N_CORES],
  output logic                      fproc_ready  [N_CORES],
  output logic [DATA_WIDTH-1:0]     fproc_data   [N_CORES],
  output logic                      id_err
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [DATA_WIDTH-1:0]     r_slot [N_MEAS];
  logic [N_CORES-1:0]        r_pend;
  logic [FPROC_ID_WIDTH-1:0] r_id   [N_CORES];
  logic [PW-1:0]             r_ptr;
  logic [N_CORES-1:0]        r_ready;
  logic [DATA_WIDTH-1:0]     r_data [N_CORES];
  logic                      r_id_err;

  logic [N_CORES-1:0]        w_elig;
  logic [PW-1:0]             w_idx [N_CORES];
  logic                      w_gnt_vld;
  logic [PW-1:0]             w_gnt;
  logic [PW-1:0]             w_ptr_nxt;
  logic [FPROC_ID_WIDTH-1:0] w_gnt_id;
  logic [DATA_WIDTH-1:0]     w_rd;
  logic                      w_in_range;

  function automatic logic id_hit(input logic [FPROC_ID_WIDTH-1:0] id, input int k);
    return (int'(id) == k);
  endfunction

`ifdef FPROC_STALE_BLOCK_EN
  logic [N_MEAS-1:0] r_fresh;

  // Out-of-range ids never match a slot and so stay eligible.
  function automatic logic fresh_ok(input logic [FPROC_ID_WIDTH-1:0] id,
                                    input logic [N_MEAS-1:0] fresh);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < N_MEAS; k++) begin
      ok = id_hit(id, k) ? fresh[k] : ok;
    end
    return ok;
  endfunction
`endif

  always_comb begin
    w_elig = '0;
    for (int c = 0; c < N_CORES; c++) begin
`ifdef FPROC_STALE_BLOCK_EN
      w_elig[c] = r_pend[c] && fresh_ok(r_id[c], r_fresh);
`else
      w_elig[c] = r_pend[c];
`endif
    end
  end

  // Search order starts at the pointer; the first eligible core wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_idx[i] = PW'((int'(r_ptr) + i) % N_CORES);
      if (!w_gnt_vld && w_elig[w_idx[i]]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx[i];
      end else begin
        w_gnt_vld = w_gnt_vld;
      end
    end
    w_ptr_nxt = (w_gnt == PW'(N_CORES - 1)) ? '0 : w_gnt + 1'b1;
  end

  // A same-cycle update of the requested slot is forwarded instead of the stored value.
  always_comb begin
    w_gnt_id   = r_id[w_gnt];
    w_rd       = '0;
    w_in_range = 1'b0;
    for (int k = 0; k < N_MEAS; k++) begin
      if (id_hit(w_gnt_id, k)) begin
        w_in_range = 1'b1;
        w_rd       = meas_valid[k] ? meas_data[k] : r_slot[k];
      end else begin
        w_in_range = w_in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend   <= '0;
      r_ptr    <= '0;
      r_ready  <= '0;
      r_id_err <= 1'b0;
      for (int k = 0; k < N_MEAS; k++) r_slot[k] <= '0;
      for (int c = 0; c < N_CORES; c++) begin
        r_id[c]   <= '0;
        r_data[c] <= '0;
      end
    end else begin
      for (int k = 0; k < N_MEAS; k++) begin
        if (meas_valid[k]) r_slot[k] <= meas_data[k];
      end
      r_ready  <= '0;
      r_id_err <= 1'b0;
      for (int c = 0; c < N_CORES; c++) begin
        r_data[c] <= '0;
        // Pending cores (including the one granted now) ignore further enables.
        if (fproc_enable[c] && !r_pend[c]) begin
          r_pend[c] <= 1'b1;
          r_id[c]   <= fproc_id[c];
        end
      end
      if (w_gnt_vld) begin
        r_pend[w_gnt]  <= 1'b0;
        r_ready[w_gnt] <= 1'b1;
        r_data[w_gnt]  <= w_rd;
        r_id_err       <= !w_in_range;
        r_ptr          <= w_ptr_nxt;
      end
    end
  end

`ifdef FPROC_STALE_BLOCK_EN
  // A grant consumes the slot even when it coincides with an update, since that update is forwarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fresh <= '0;
    end else begin
      for (int k = 0; k < N_MEAS; k++) begin
        if (w_gnt_vld && id_hit(w_gnt_id, k)) r_fresh[k] <= 1'b0;
        else if (meas_valid[k])               r_fresh[k] <= 1'b1;
      end
    end
  end
`endif

  for (genvar c = 0; c < N_CORES; c++) begin : g_out
    assign fproc_ready[c] = r_ready[c];
    assign fproc_data[c]  = r_data[c];
  end
  assign id_err = r_id_err;

endmodule

// File: tb/tb_fproc_meas_hub.sv
// Directed bench for fproc_meas_hub; expected responses are queued with their due cycle and
// checked every cycle against all ready/data lanes and id_err.
module tb_fproc_meas_hub;

  localparam int NC = 8;
  localparam int NM = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        meas_valid   [NM];
  logic [31:0] meas_data    [NM];
  logic        fproc_enable [NC];
  logic [7:0]  fproc_id     [NC];
  logic        fproc_ready  [NC];
  logic [31:0] fproc_data   [NC];
  logic        id_err;

  typedef struct {
    int          cyc;
    int          core;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  fproc_meas_hub #(.N_CORES(NC), .DATA_WIDTH(32), .FPROC_ID_WIDTH(8), .N_MEAS(NM)) dut (
    .clk(clk), .reset(reset),
    .meas_valid(meas_valid), .meas_data(meas_data),
    .fproc_enable(fproc_enable), .fproc_id(fproc_id),
    .fproc_ready(fproc_ready), .fproc_data(fproc_data),
    .id_err(id_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    for (int k = 0; k < NM; k++) begin
      meas_valid[k] = 1'b0;
      meas_data[k]  = 32'h0;
    end
    for (int c = 0; c < NC; c++) begin
      fproc_enable[c] = 1'b0;
      fproc_id[c]     = 8'h0;
    end
  endtask

  task automatic expect_rsp(input int core, input logic [31:0] data, input logic err, input int lat);
    exp_t e;
    e.cyc  = cyc + lat;
    e.core = core;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic request(input int core, input logic [7:0] id);
    fproc_enable[core] = 1'b1;
    fproc_id[core]     = id;
  endtask

  task automatic update(input int slot, input logic [31:0] data);
    meas_valid[slot] = 1'b1;
    meas_data[slot]  = data;
  endtask

  // One clock edge, then every output lane is compared against what is due this cycle.
  task automatic step();
    logic [NC-1:0] er;
    logic [31:0]   ed [NC];
    logic          ee;
    @(posedge clk);
    cyc++;
    #1;
    er = '0;
    ee = 1'b0;
    for (int c = 0; c < NC; c++) ed[c] = 32'h0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        er[sb[i].core] = 1'b1;
        ed[sb[i].core] = sb[i].data;
        ee             = ee | sb[i].err;
        sb.delete(i);
      end
    end
    for (int c = 0; c < NC; c++) begin
      checks++;
      assert (fproc_ready[c] === er[c]) else begin
        errors++;
        $error("FAIL ready[%0d] cyc %0d observed %b expected %b", c, cyc, fproc_ready[c], er[c]);
      end
      checks++;
      assert (fproc_data[c] === ed[c]) else begin
        errors++;
        $error("FAIL data[%0d] cyc %0d observed %h expected %h", c, cyc, fproc_data[c], ed[c]);
      end
    end
    checks++;
    assert (id_err === ee) else begin
      errors++;
      $error("FAIL id_err cyc %0d observed %b expected %b", cyc, id_err, ee);
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    step(); step(); step();
    reset = 1'b1;
    step();

    for (int k = 0; k < NM; k++) update(k, 32'h100 + k);
    step();
    clear_inputs();

    request(0, 8'd7); request(1, 8'd6); request(5, 8'd3);
    expect_rsp(0, 32'h107, 1'b0, 2);
    expect_rsp(1, 32'h106, 1'b0, 3);
    expect_rsp(5, 32'h103, 1'b0, 4);
    step(); clear_inputs();
    repeat (4) step();

    request(0, 8'd0); request(5, 8'd1);
    expect_rsp(0, 32'h100, 1'b0, 2);
    expect_rsp(5, 32'h101, 1'b0, 3);
    step(); clear_inputs();
    repeat (3) step();

    update(3, 32'hDEADBEEF);
    step(); clear_inputs();
    request(2, 8'd3);
    expect_rsp(2, 32'hDEADBEEF, 1'b0, 2);
    step(); clear_inputs();
    repeat (3) step();

    request(3, 8'd4);
    expect_rsp(3, 32'h12345678, 1'b0, 2);
    step(); clear_inputs();
    update(4, 32'h12345678);
    step(); clear_inputs();
    repeat (3) step();

    request(1, 8'd200);
    expect_rsp(1, 32'h0, 1'b1, 2);
    step(); clear_inputs();
    repeat (3) step();

    request(6, 8'd5);
    expect_rsp(6, 32'h105, 1'b0, 2);
    step(); clear_inputs();
    request(6, 8'd1);
    step(); clear_inputs();
    request(6, 8'd200);
    expect_rsp(6, 32'h0, 1'b1, 2);
    step(); clear_inputs();
    repeat (3) step();

    request(0, 8'd2);
    expect_rsp(0, 32'h102, 1'b0, 2);
    step(); clear_inputs();
    step();
    request(0, 8'd2);
`ifdef FPROC_STALE_BLOCK_EN
    step(); clear_inputs();
    repeat (4) step();
    update(2, 32'hCAFE0002);
    expect_rsp(0, 32'hCAFE0002, 1'b0, 2);
    step(); clear_inputs();
`else
    expect_rsp(0, 32'h102, 1'b0, 2);
    step(); clear_inputs();
`endif
    repeat (3) step();

    for (int c = 0; c < 4; c++) request(c, 8'(c));
    step(); clear_inputs();
    reset = 1'b0;
    request(7, 8'd0);
    update(5, 32'h55);
    step(); clear_inputs();
    reset = 1'b1;
    repeat (5) step();

`ifndef FPROC_STALE_BLOCK_EN
    request(4, 8'd5);
    expect_rsp(4, 32'h0, 1'b0, 2);
    step(); clear_inputs();
    repeat (2) step();
`endif
    update(1, 32'hA5A5A5A5);
    step(); clear_inputs();
    request(4, 8'd1);
    expect_rsp(4, 32'hA5A5A5A5, 1'b0, 2);
    step(); clear_inputs();
    repeat (3) step();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fproc_meas_hub.md
FPROC_MEAS_HUB -- requirements
Module: fproc_meas_hub

Interface
REQ-001 SHALL have parameter N_CORES, default 8: number of DSP-unit fproc request channels served.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of a result word.
REQ-003 SHALL have parameter FPROC_ID_WIDTH, default 8: width of a request id.
REQ-004 SHALL have parameter N_MEAS, default 8: number of result slots, indexed by id.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port meas_valid, input, [0:0] x N_MEAS unpacked: one-cycle pulse marking a new result for slot k.
REQ-008 SHALL have port meas_data, input, DATA_WIDTH x N_MEAS unpacked: result for slot k, qualified by meas_valid[k].
REQ-009 SHALL have port fproc_enable, input, [0:0] x N_CORES unpacked: one-cycle request pulse from core c.
REQ-010 SHALL have port fproc_id, input, FPROC_ID_WIDTH x N_CORES unpacked: slot requested by core c, qualified by fproc_enable[c].
REQ-011 SHALL have port fproc_ready, output, [0:0] x N_CORES unpacked: one-cycle response strobe to core c.
REQ-012 SHALL have port fproc_data, output, DATA_WIDTH x N_CORES unpacked: response word to core c, qualified by fproc_ready[c].
REQ-013 SHALL have port id_err, output, 1: one-cycle pulse when a response is issued for an id >= N_MEAS.

Function
REQ-014 SHALL hold N_MEAS result registers; meas_valid[k] high at edge t writes meas_data[k] into slot k, visible from cycle t+1.
REQ-015 SHALL latch a per-core pending flag and id when fproc_enable[c] is sampled high and core c has no pending request.
REQ-016 SHALL ignore fproc_enable[c] while core c is pending or is being answered in that cycle.
REQ-017 SHALL grant exactly one eligible pending core per cycle, in round-robin order starting at the core after the last granted core, modulo N_CORES.
REQ-018 SHALL set the round-robin pointer to core 0 out of reset.
REQ-019 SHALL assert fproc_ready[c] for exactly one cycle, on the cycle after the grant, and clear pending[c] on the same edge.
REQ-020 SHALL respond in 2 cycles when uncontended: enable in cycle 0 -> ready in cycle 2.
REQ-021 SHALL drive fproc_data[c] with the slot value read at the grant, and with zero whenever fproc_ready[c] is low.
REQ-022 SHALL forward meas_data[k] when meas_valid[k] and a grant for slot k occur in the same cycle.
REQ-023 SHALL answer an id >= N_MEAS with data zero at normal latency, and pulse id_err with that ready.
REQ-024 SHALL let core c re-request in the same cycle that fproc_ready[c] is asserted; that request is captured and served normally.

Reset
REQ-025 SHALL, while reset is low at a clk edge, clear all pending flags, fresh flags, result slots, the round-robin pointer, fproc_ready, fproc_data and id_err to zero.
REQ-026 SHALL drop outstanding requests when reset is asserted mid-operation, with no late ready after reset is released.
REQ-027 SHALL ignore meas_valid and fproc_enable on edges where reset is low.

Configuration
REQ-028 SHALL support macro FPROC_STALE_BLOCK_EN; with it defined, each slot keeps a fresh bit that meas_valid sets and a grant on that slot clears.
REQ-029 SHALL, with FPROC_STALE_BLOCK_EN defined, treat a pending request as eligible only while fresh[id] is set, so that a request for a stale slot waits for the next meas_valid.
REQ-030 SHALL, with FPROC_STALE_BLOCK_EN defined and several cores waiting on one slot, serve only the round-robin winner per update; the other cores wait for the next update.
REQ-031 SHALL, with FPROC_STALE_BLOCK_EN defined, treat out-of-range ids as always eligible.
REQ-032 SHALL, without FPROC_STALE_BLOCK_EN, treat every pending request as eligible and not implement fresh bits.

Verification
REQ-033 SHALL cover: meas_valid[3]=1 with data 0xDEADBEEF, then core 2 enable with id 3 -> fproc_ready[2] 2 cycles later, data 0xDEADBEEF.
REQ-034 SHALL cover: cores 0, 1 and 5 enable together after reset -> ready in order 0, 1, 5 on consecutive cycles, then core 0 and core 5 together -> core 0 served first.
REQ-035 SHALL cover: meas_valid[4] with 0x12345678 in the same cycle as the grant for id 4 -> response data 0x12345678.
REQ-036 SHALL cover: core 1 requests id 200 -> fproc_ready[1] with data 0 and a single id_err pulse.
REQ-037 SHALL cover, with FPROC_STALE_BLOCK_EN: core 0 reads slot 2 twice -> second ready held off until meas_valid[2], then issued 2 cycles later.
REQ-038 SHALL cover: reset low for 1 cycle while 4 requests are pending -> no fproc_ready after release, and a new request is served at 2-cycle latency.
